score_table: RTL

- Sequential score store sitting directly upstream of the ranking stage.
- Holds the best score of each of 8 users for each of 3 songs (LittleStar, JiLeJingTu, ChunXiaQiuDong).
- Accepts one score commit at a time over a valid/ready handshake and updates the user's entry.
- Exposes each song's table as a packed 80-bit bus (user u at bits [u*10+9 : u*10]) for the ranking stage to sort.

---
 rtl/score_table.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/score_table.sv
`default_nettype none
// ============================================================================
// Module   : score_table
// Summary  : Best-score store for 8 users x 3 songs, 10-bit entries, with a
//            valid/ready commit path and a 24-cycle sequential clear.
// Revision : 1.0  initial release
// ============================================================================
module score_table #(
  parameter int MAX_SCORE = 1023,
  parameter int KEEP_BEST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [2:0]  commit_user,
  input  logic [2:0]  commit_choice,
  input  logic [9:0]  commit_score,
  input  logic        clear_req,
  output logic        busy,
  output logic        done,
  output logic        new_record,
  output logic        err,
  output logic [79:0] LittleStar,
  output logic [79:0] JiLeJingTu,
  output logic [79:0] ChunXiaQiuDong
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  localparam logic [9:0] c_max_score = 10'(MAX_SCORE);
  localparam logic [4:0] c_last_idx  = 5'd23;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [2:0]  r_user;
  logic [2:0]  r_choice;
  logic [9:0]  r_score;
  logic        r_wr_en;
  logic        r_rec;
  logic        r_err;
  logic [4:0]  r_idx;

  logic        w_onehot;
  logic        w_accept;
  logic [9:0]  w_clamped;
  logic [9:0]  w_stored;
  logic [6:0]  w_rd_off;
  logic [6:0]  w_wr_off;
  logic [9:0]  w_wr_data;
  logic [79:0] w_rows [0:2];

  // Bit offset of a user's field: user * 10.
  function automatic logic [6:0] f_off(input logic [2:0] u);
    return {1'b0, u, 3'b000} + {3'b000, u, 1'b0};
  endfunction

  assign w_onehot  = (commit_choice == 3'b001) || (commit_choice == 3'b010) ||
                     (commit_choice == 3'b100);
  assign w_accept  = (r_state == S_IDLE) && commit_valid && !clear_req;
  assign w_clamped = (commit_score > c_max_score) ? c_max_score : commit_score;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_next = S_CLEAR;
        end else if (commit_valid && w_onehot) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_CLEAR: begin
        if (r_idx == c_last_idx) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    commit_ready = (r_state == S_IDLE);
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    new_record   = (r_state == S_DONE) && r_rec;
  end

  assign err = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_user   <= 3'd0;
      r_choice <= 3'd0;
      r_score  <= 10'd0;
      r_wr_en  <= 1'b0;
      r_rec    <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= 5'd0;
    end else begin
      r_err <= w_accept && !w_onehot;
      if (w_accept) begin
        r_user   <= commit_user;
        r_choice <= commit_choice;
        r_score  <= w_clamped;
      end
      if (r_state == S_CHECK) begin
        r_rec   <= (r_score > w_stored);
        r_wr_en <= (KEEP_BEST != 0) ? (r_score > w_stored) : 1'b1;
      end
      if (r_state == S_CLEAR) begin
        r_idx <= r_idx + 5'd1;
      end else begin
        r_idx <= 5'd0;
      end
    end
  end

  assign w_rd_off = f_off(r_user);

  always_comb begin
    w_stored = 10'd0;
    if (r_choice[0]) w_stored = w_rows[0][w_rd_off +: 10];
    if (r_choice[1]) w_stored = w_rows[1][w_rd_off +: 10];
    if (r_choice[2]) w_stored = w_rows[2][w_rd_off +: 10];
  end

  // The clear walk and the commit write share one write port per song row.
  assign w_wr_off  = (r_state == S_CLEAR) ? f_off(r_idx[2:0]) : w_rd_off;
  assign w_wr_data = (r_state == S_CLEAR) ? 10'd0 : r_score;

  generate
    for (genvar s = 0; s < 3; s++) begin : g_song
      logic [79:0] r_row;
      logic        w_wr;

      assign w_wr = ((r_state == S_WRITE) && r_wr_en && r_choice[s]) ||
                    ((r_state == S_CLEAR) && (r_idx[4:3] == 2'(s)));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_row <= 80'd0;
        end else if (w_wr) begin
          r_row[w_wr_off +: 10] <= w_wr_data;
        end
      end

      assign w_rows[s] = r_row;
    end
  endgenerate

  assign LittleStar     = w_rows[0];
  assign JiLeJingTu     = w_rows[1];
  assign ChunXiaQiuDong = w_rows[2];

endmodule
`default_nettype wire
